// File: rtl/dna_pkg.sv
// Shared definitions for the DNA_PORT read sequencer.
package dna_pkg;

  localparam int DNA_ID_WIDTH   = 57;
  localparam int DNA_PAD_WIDTH  = 7;
  localparam int DNA_DATA_WIDTH = DNA_ID_WIDTH + DNA_PAD_WIDTH;

  // Wide enough to count DNA clock periods 0..DNA_ID_WIDTH-1.
  localparam int DNA_PERIOD_W   = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PASS_A  = 2'd1,
    PASS_B  = 2'd2,
    COMPARE = 2'd3
  } dna_state_t;

endpackage

// File: rtl/dna_shift_engine.sv
// One read pass of the DNA_PORT: divides aclk down to the DNA clock, issues
// READ in the first DNA period and SHIFT in the remaining 56, and captures
// DOUT at the end of every period into a 57-bit MSB-first word.
module dna_shift_engine
  import dna_pkg::*;
#(
  parameter int DIV_LOG2 = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic                    dout,
  output logic                    dna_clk,
  output logic                    dna_read,
  output logic                    dna_shift,
  output logic                    pass_done,
  output logic [DNA_ID_WIDTH-1:0] pass_data
);

  localparam logic [DNA_PERIOD_W-1:0] LAST_PERIOD = DNA_PERIOD_W'(DNA_ID_WIDTH - 1);

  logic [DIV_LOG2-1:0]     cnt;
  logic [DNA_PERIOD_W-1:0] period;
  logic [DNA_ID_WIDTH-1:0] shreg;
  logic                    sample;

  // DOUT is taken on the last aclk of each DNA period, well after the
  // DNA clock rising edge in the middle of the period.
  assign sample    = run && (&cnt);
  assign pass_done = sample && (period == LAST_PERIOD);

  // The word including the bit being sampled right now, so the caller can
  // latch the complete ID on the pass_done cycle.
  assign pass_data = {shreg[DNA_ID_WIDTH-2:0], dout};

  // Counter is held at zero outside a pass, so the DNA clock idles low.
  assign dna_clk   = cnt[DIV_LOG2-1];
  assign dna_read  = run && (period == '0);
  assign dna_shift = run && (period != '0);

  // Divider and DNA period counters; restart from zero for the next pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      period <= '0;
    end else if (!run || pass_done) begin
      cnt    <= '0;
      period <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (&cnt) begin
        period <= period + 1'b1;
      end
    end
  end

  // Capture shift register, MSB-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (!run || pass_done) begin
      shreg <= '0;
    end else if (sample) begin
      shreg <= pass_data;
    end
  end

endmodule

// File: rtl/dna_port_sequencer.sv
// Reads the device DNA twice per attempt, accepts the ID only when both
// passes agree, and retries up to MAX_RETRY times before flagging an error.
module dna_port_sequencer
  import dna_pkg::*;
#(
  parameter int DIV_LOG2   = 6,
  parameter int MAX_RETRY  = 3,
  parameter int AUTO_START = 1
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      dna_valid,
  output logic                      dna_error,
  output logic [DNA_DATA_WIDTH-1:0] dna_data,
  output logic                      dna_clk,
  output logic                      dna_read,
  output logic                      dna_shift,
  input  logic                      dna_dout
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);

  dna_state_t state, next_state;

  logic                    auto_pend;
  logic [RETRY_W-1:0]      retry;
  logic [DNA_ID_WIDTH-1:0] reg_a;
  logic [DNA_ID_WIDTH-1:0] reg_b;
  logic                    run;
  logic                    pass_done;
  logic [DNA_ID_WIDTH-1:0] pass_data;
  logic                    ids_match;
  logic                    go;
  logic                    finish_ok;
  logic                    finish_fail;
  logic                    retry_again;

  assign run       = (state == PASS_A) || (state == PASS_B);
  assign busy      = (state != IDLE);
  assign ids_match = (reg_a == reg_b);

  dna_shift_engine #(
    .DIV_LOG2 (DIV_LOG2)
  ) u_engine (
    .clk       (aclk),
    .rst_n     (aresetn),
    .run       (run),
    .dout      (dna_dout),
    .dna_clk   (dna_clk),
    .dna_read  (dna_read),
    .dna_shift (dna_shift),
    .pass_done (pass_done),
    .pass_data (pass_data)
  );

  // Next-state and sequencing decisions.
  always_comb begin
    next_state  = state;
    go          = 1'b0;
    finish_ok   = 1'b0;
    finish_fail = 1'b0;
    retry_again = 1'b0;
    unique case (state)
      IDLE: begin
        // The done cycle already shows IDLE, but a start arriving with done
        // belongs to the sequence that is just ending and is dropped.
        if ((start && !done) || auto_pend) begin
          go         = 1'b1;
          next_state = PASS_A;
        end
      end
      PASS_A: begin
        if (pass_done) begin
          next_state = PASS_B;
        end
      end
      PASS_B: begin
        if (pass_done) begin
          next_state = COMPARE;
        end
      end
      COMPARE: begin
        if (ids_match) begin
          finish_ok  = 1'b1;
          next_state = IDLE;
        end else if (retry == RETRY_LAST) begin
          finish_fail = 1'b1;
          next_state  = IDLE;
        end else begin
          retry_again = 1'b1;
          next_state  = PASS_A;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // One-shot request that launches a sequence right after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      auto_pend <= (AUTO_START != 0);
    end else if (go) begin
      auto_pend <= 1'b0;
    end
  end

  // Attempt counter: zero on a new sequence, bumped on every retry.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      retry <= '0;
    end else if (go) begin
      retry <= '0;
    end else if (retry_again) begin
      retry <= retry + 1'b1;
    end
  end

  // Per-pass ID words, latched as each pass completes.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      reg_a <= '0;
      reg_b <= '0;
    end else if (retry_again) begin
      reg_a <= '0;
      reg_b <= '0;
    end else if (pass_done && (state == PASS_A)) begin
      reg_a <= pass_data;
    end else if (pass_done && (state == PASS_B)) begin
      reg_b <= pass_data;
    end
  end

  // Result registers and the done pulse.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      done      <= 1'b0;
      dna_valid <= 1'b0;
      dna_error <= 1'b0;
      dna_data  <= '0;
    end else begin
      done <= finish_ok || finish_fail;
      if (go) begin
        dna_valid <= 1'b0;
        dna_error <= 1'b0;
      end else if (finish_ok) begin
        dna_data  <= {reg_a, {DNA_PAD_WIDTH{1'b0}}};
        dna_valid <= 1'b1;
        dna_error <= 1'b0;
      end else if (finish_fail) begin
        dna_valid <= 1'b0;
        dna_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dna_port_sequencer.sv
// Scoreboard bench: each request pushes its expected result; a monitor pops
// and compares whenever done pulses.
module tb_dna_port_sequencer;

  localparam int DIV_LOG2  = 2;
  localparam int MAX_RETRY = 3;
  localparam int ATTEMPTS  = MAX_RETRY + 1;
  localparam int P         = 57 * (2 ** DIV_LOG2);
  localparam int ATT_CYC   = 2 * P + 1;
  localparam logic [56:0] REF_ID = 57'h15A5A5A5A5A5A5A;

  typedef struct {
    int          done_cyc;
    logic        valid;
    logic        err;
    logic [63:0] data;
  } exp_t;

  logic        aclk = 1'b0;
  logic        aresetn, rst_auto, start;
  logic        busy, done, dna_valid, dna_error, dna_clk, dna_read, dna_shift, dna_dout;
  logic [63:0] dna_data;
  logic        busy_a, done_a, valid_a, error_a, clk_a, read_a, shift_a, dout_a;
  logic [63:0] data_a;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [56:0] pass_q[$];
  logic [56:0] dna_sr = '0;
  logic [56:0] dna_sr_a = '0;
  logic [56:0] pa[ATTEMPTS];
  logic [56:0] pb[ATTEMPTS];
  logic [63:0] last_good = '0;
  int          auto_exp_cyc = -1;
  int          auto_dones = 0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc = cyc + 1;

  dna_port_sequencer #(
    .DIV_LOG2   (DIV_LOG2),
    .MAX_RETRY  (MAX_RETRY),
    .AUTO_START (0)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .dna_valid (dna_valid),
    .dna_error (dna_error),
    .dna_data  (dna_data),
    .dna_clk   (dna_clk),
    .dna_read  (dna_read),
    .dna_shift (dna_shift),
    .dna_dout  (dna_dout)
  );

  dna_port_sequencer #(
    .DIV_LOG2   (DIV_LOG2),
    .MAX_RETRY  (MAX_RETRY),
    .AUTO_START (1)
  ) dut_auto (
    .aclk      (aclk),
    .aresetn   (rst_auto),
    .start     (1'b0),
    .busy      (busy_a),
    .done      (done_a),
    .dna_valid (valid_a),
    .dna_error (error_a),
    .dna_data  (data_a),
    .dna_clk   (clk_a),
    .dna_read  (read_a),
    .dna_shift (shift_a),
    .dna_dout  (dout_a)
  );

  // DNA_PORT model: READ loads the next queued word, SHIFT moves it out MSB-first.
  always @(posedge dna_clk) begin
    if (dna_read) begin
      if (pass_q.size() > 0) dna_sr <= pass_q.pop_front();
      else                   dna_sr <= '0;
    end else if (dna_shift) begin
      dna_sr <= {dna_sr[55:0], 1'b0};
    end
  end
  assign dna_dout = dna_sr[56];

  always @(posedge clk_a) begin
    if (read_a)       dna_sr_a <= REF_ID;
    else if (shift_a) dna_sr_a <= {dna_sr_a[55:0], 1'b0};
  end
  assign dout_a = dna_sr_a[56];

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%b required=%b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic checki(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [56:0] rand57();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[56:0];
  endfunction

  function automatic logic [56:0] rand_mask();
    logic [56:0] m;
    m = rand57();
    if (m == '0) m = 57'h1;
    return m;
  endfunction

  // Monitor for the main instance.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (!busy) check1("dna_clk_idle_low", dna_clk, 1'b0);
      if (done) begin
        if (sb.size() == 0) begin
          check1("spurious_done", done, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          checki("done_cycle", cyc, mon_e.done_cyc);
          check1("busy_low_at_done", busy, 1'b0);
          check1("dna_valid", dna_valid, mon_e.valid);
          check1("dna_error", dna_error, mon_e.err);
          check64("dna_data", dna_data, mon_e.data);
        end
      end
    end
  end

  // Monitor for the auto-start instance.
  always @(negedge aclk) begin
    if (rst_auto && done_a) begin
      auto_dones++;
      checki("auto_done_cycle", cyc, auto_exp_cyc);
      check1("auto_valid", valid_a, 1'b1);
      check1("auto_error", error_a, 1'b0);
      check64("auto_data", data_a, {REF_ID, 7'h0});
    end
  end

  // Reference outcome: the first attempt whose two passes agree wins;
  // if none of the attempts agree, the sequence ends in error.
  task automatic run_txn(input string tag);
    exp_t e;
    int   n_att;
    int   t;
    n_att = 0;
    for (int a = 0; a < ATTEMPTS; a++) begin
      pass_q.push_back(pa[a]);
      pass_q.push_back(pb[a]);
      if (pa[a] == pb[a]) begin
        n_att = a + 1;
        break;
      end
    end
    if (n_att > 0) begin
      e.valid   = 1'b1;
      e.err     = 1'b0;
      e.data    = {pa[n_att-1], 7'h0};
      last_good = e.data;
    end else begin
      n_att  = ATTEMPTS;
      e.valid = 1'b0;
      e.err   = 1'b1;
      e.data  = last_good;
    end
    @(negedge aclk);
    t          = cyc;
    start      = 1'b1;
    e.done_cyc = t + n_att * ATT_CYC + 1;
    sb.push_back(e);
    @(negedge aclk);
    start = 1'b0;
    check1({tag, "_busy_rise"}, busy, 1'b1);
    check1({tag, "_valid_cleared"}, dna_valid, 1'b0);
    check1({tag, "_error_cleared"}, dna_error, 1'b0);
    while (cyc < t + 10) @(negedge aclk);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    while (cyc < t + 300) @(negedge aclk);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    while (cyc < e.done_cyc) @(negedge aclk);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    repeat (4) @(negedge aclk);
    check1({tag, "_idle_after_done"}, busy, 1'b0);
    checki({tag, "_done_seen"}, sb.size(), 0);
    sb.delete();
    pass_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, "_busy"}, busy, 1'b0);
    check1({tag, "_done"}, done, 1'b0);
    check1({tag, "_valid"}, dna_valid, 1'b0);
    check1({tag, "_error"}, dna_error, 1'b0);
    check1({tag, "_dna_clk"}, dna_clk, 1'b0);
    check1({tag, "_dna_read"}, dna_read, 1'b0);
    check1({tag, "_dna_shift"}, dna_shift, 1'b0);
    check64({tag, "_data"}, dna_data, 64'h0);
  endtask

  task automatic reset_mid_pass();
    int t;
    pa[0] = rand57();
    pb[0] = pa[0];
    pass_q.push_back(pa[0]);
    pass_q.push_back(pb[0]);
    @(negedge aclk);
    t     = cyc;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    while (cyc < t + 100) @(negedge aclk);
    check1("pre_reset_busy", busy, 1'b1);
    check1("pre_reset_valid_held_low", dna_valid, 1'b0);
    #2 aresetn = 1'b0;
    #1 check_all_zero("async_reset");
    sb.delete();
    pass_q.delete();
    last_good = '0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    repeat (50) @(negedge aclk);
    check1("no_auto_start_busy", busy, 1'b0);
    check64("no_auto_start_data", dna_data, 64'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    aresetn  = 1'b0;
    rst_auto = 1'b0;
    start    = 1'b0;
    for (int i = 0; i < ATTEMPTS; i++) begin
      pa[i] = '0;
      pb[i] = '0;
    end
    repeat (3) @(negedge aclk);
    check_all_zero("reset");
    check1("reset_auto_busy", busy_a, 1'b0);
    check1("reset_auto_clk", clk_a, 1'b0);

    @(negedge aclk);
    auto_exp_cyc = cyc + ATT_CYC + 1;
    aresetn      = 1'b1;
    rst_auto     = 1'b1;

    // Clean read of the reference ID.
    for (int i = 0; i < ATTEMPTS; i++) begin
      pa[i] = REF_ID;
      pb[i] = REF_ID;
    end
    run_txn("basic");

    // Second pass of the first attempt has bit 0 flipped.
    for (int i = 0; i < ATTEMPTS; i++) begin
      pa[i] = REF_ID;
      pb[i] = REF_ID;
    end
    pb[0] = REF_ID ^ 57'h1;
    run_txn("retry_once");

    // Every pass random: all attempts mismatch, prior data retained.
    for (int i = 0; i < ATTEMPTS; i++) begin
      pa[i] = rand57();
      pb[i] = pa[i] ^ rand_mask();
    end
    run_txn("exhausted");

    reset_mid_pass();

    // Random IDs with random corruption per attempt.
    for (int n = 0; n < 5; n++) begin
      logic [56:0] id;
      id = rand57();
      for (int i = 0; i < ATTEMPTS; i++) begin
        pa[i] = id;
        pb[i] = ($urandom_range(0, 1) == 1) ? id : (id ^ rand_mask());
      end
      run_txn("random");
    end

    repeat (20) @(negedge aclk);
    checki("auto_done_count", auto_dones, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
